// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: state encoding, default timing and transfer-direction constants for the sequencer
package i2c_seq_pkg;
  localparam int TIMEOUT_CYCLES_DEF = 64;
  localparam int MRST_CYCLES_DEF = 2;
  localparam logic RW_READ = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MRST = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WAIT1 = 3'd3;
  localparam logic [2:0] S_WAIT2 = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;
endpackage

// File: rtl/i2c_sequencer.sv
// i2c_sequencer: runs one I2C master transaction per command (reset master, launch, await two acks) and returns a response
module i2c_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int MRST_CYCLES = MRST_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_reg,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       busy,
  output logic       m_rst_n,
  output logic       m_en,
  output logic       m_start,
  output logic       m_stop,
  output logic       m_repeat_start,
  output logic       m_mode,
  output logic [6:0] m_address,
  output logic [7:0] m_register,
  input  logic       m_ack,
  input  logic [7:0] m_data
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + MRST_CYCLES + 2);
  localparam logic [CW-1:0] MRST_LAST = CW'(MRST_CYCLES - 1);
  localparam logic [CW-1:0] TOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [2:0] r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic r_cmd_ready, r_ack, r_rw, r_rsp_err;
  logic [6:0] r_addr;
  logic [7:0] r_reg, r_rsp_data;
  logic w_rise, w_accept, w_done, w_op, w_enter_resp;
  assign w_rise = m_ack & ~r_ack;
  assign w_accept = (r_state == S_IDLE) & r_cmd_ready & cmd_valid;
  assign w_done = (r_state == S_WAIT2) & w_rise;
  assign w_enter_resp = (w_state_nxt == S_RESP) & (r_state != S_RESP);
  assign w_op = (r_state == S_MRST) | (r_state == S_LAUNCH) | (r_state == S_WAIT1) | (r_state == S_WAIT2);
  assign cmd_ready = r_cmd_ready;
  assign busy = r_state != S_IDLE;
  assign rsp_valid = r_state == S_RESP;
  assign rsp_data = r_rsp_data;
  assign rsp_err = r_rsp_err;
  assign m_rst_n = (r_state == S_LAUNCH) | (r_state == S_WAIT1) | (r_state == S_WAIT2);
  assign m_en = r_state == S_LAUNCH;
  assign m_start = r_state == S_LAUNCH;
  assign m_stop = w_op;
  assign m_repeat_start = 1'b0;
  assign m_mode = w_op ? r_rw : RW_WRITE;
  assign m_address = w_op ? r_addr : '0;
  assign m_register = w_op ? r_reg : '0;
  // next state and shared master-reset / timeout counter; an ack edge takes priority over expiry
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = w_accept ? S_MRST : S_IDLE;
        w_cnt_nxt = w_accept ? '0 : r_cnt;
      end
      S_MRST: begin
        w_state_nxt = (r_cnt == MRST_LAST) ? S_LAUNCH : S_MRST;
        w_cnt_nxt = (r_cnt == MRST_LAST) ? '0 : r_cnt + CW'(1);
      end
      S_LAUNCH: begin
        w_state_nxt = S_WAIT1;
        w_cnt_nxt = '0;
      end
      S_WAIT1, S_WAIT2: begin
        w_cnt_nxt = r_cnt + CW'(1);
        w_state_nxt = w_rise ? ((r_state == S_WAIT1) ? S_WAIT2 : S_RESP) : (r_cnt >= TOUT_LAST) ? S_RESP : r_state;
      end
      S_RESP: w_state_nxt = rsp_ready ? S_IDLE : S_RESP;
      default: w_state_nxt = S_IDLE;
    endcase
  end
  // state, counter, ack history, latched command and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_cmd_ready <= 1'b0;
      r_ack <= 1'b0;
      r_rw <= 1'b0;
      r_addr <= '0;
      r_reg <= '0;
      r_rsp_data <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      r_cmd_ready <= w_state_nxt == S_IDLE;
      r_ack <= m_ack;
      if (w_accept) begin
        r_rw <= cmd_rw;
        r_addr <= cmd_addr;
        r_reg <= cmd_reg;
      end
      if (w_enter_resp) begin
        r_rsp_data <= (w_done && r_rw == RW_READ) ? m_data : '0;
        r_rsp_err <= ~w_done;
      end
    end
  end
endmodule

// File: tb/tb_i2c_sequencer.sv
// tb_i2c_sequencer: directed transactions against a behavioural I2C master, checked every cycle against an edge-time model
module tb_i2c_sequencer;
  localparam int TOUT = 64;
  localparam int MRST = 2;
  logic clk = 0, reset = 0, cmd_valid = 0, cmd_rw = 0, rsp_ready = 0, m_ack = 0;
  logic [6:0] cmd_addr = 0;
  logic [7:0] cmd_reg = 0, m_data = 0;
  logic cmd_ready, rsp_valid, rsp_err, busy, m_rst_n, m_en, m_start, m_stop, m_repeat_start, m_mode;
  logic [6:0] m_address;
  logic [7:0] rsp_data, m_register;
  i2c_sequencer #(.TIMEOUT_CYCLES(TOUT), .MRST_CYCLES(MRST)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_reg(cmd_reg), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .m_rst_n(m_rst_n), .m_en(m_en),
    .m_start(m_start), .m_stop(m_stop), .m_repeat_start(m_repeat_start), .m_mode(m_mode),
    .m_address(m_address), .m_register(m_register), .m_ack(m_ack), .m_data(m_data)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int vecs = 0, errs = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endtask
  // model: a transaction is described by its accept edge, first-ack edge and end edge
  bit tx = 0, ended = 0, x_rw = 0, x_err = 0, ack_prev = 0;
  int acc = 0, e1 = -1, live_from = -1;
  logic [6:0] x_addr = 0;
  logic [7:0] x_reg = 0, x_data = 0;
  always @(negedge clk) begin
    int e;
    bit act, rv, rise;
    e = cyc;
    if (e > 0) begin
      act = reset && tx && !ended;
      rv = reset && tx && ended;
      chk("cmd_ready", cmd_ready, reset && !tx && live_from >= 0 && e >= live_from);
      chk("busy", busy, reset && tx);
      chk("rsp_valid", rsp_valid, rv);
      chk("m_rst_n", m_rst_n, act && e >= acc + MRST);
      chk("m_en", m_en, act && e == acc + MRST);
      chk("m_start", m_start, act && e == acc + MRST);
      chk("m_stop", m_stop, act);
      chk("m_repeat_start", m_repeat_start, 0);
      chk("m_mode", m_mode, act && x_rw);
      chk("m_address", m_address, act ? x_addr : 7'h0);
      chk("m_register", m_register, act ? x_reg : 8'h0);
      if (rv || !reset) begin
        chk("rsp_data", rsp_data, rv ? x_data : 8'h0);
        chk("rsp_err", rsp_err, rv && x_err);
      end
    end
    if (!reset) begin
      tx = 0;
      ended = 0;
      live_from = -1;
      ack_prev = 0;
    end else begin
      rise = m_ack && !ack_prev;
      if (live_from < 0) live_from = e + 1;
      if (tx && !ended) begin
        if (e + 1 > acc + MRST + 1) begin
          if (e1 < 0 && rise) e1 = e + 1;
          else if (e1 >= 0 && rise) begin
            ended = 1; x_err = 0; x_data = x_rw ? m_data : 8'h0;
          end else if (e + 1 >= acc + MRST + 1 + TOUT) begin
            ended = 1; x_err = 1; x_data = 8'h0;
          end
        end
      end else if (tx) begin
        if (rsp_ready) begin tx = 0; ended = 0; end
      end else if (e >= live_from && cmd_valid) begin
        tx = 1; ended = 0; e1 = -1; acc = e + 1;
        x_rw = cmd_rw; x_addr = cmd_addr; x_reg = cmd_reg;
      end
      ack_prev = m_ack;
    end
  end
  int t_acc, t_launch, t_rsp;
  logic l_mode;
  logic [6:0] l_addr;
  logic [7:0] l_reg;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic rw, input logic [6:0] a, input logic [7:0] r);
    int n = 0;
    while (!cmd_ready && n < 20) begin step(); n++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_rw = rw; cmd_addr = a; cmd_reg = r; cmd_valid = 1;
    step();
    cmd_valid = 0;
    t_acc = cyc;
  endtask
  // behavioural master: first ack rise g1 edges into WAIT1, second rise g2 idle edges later
  task automatic run_master(input int g1, input int g2, input int np, input logic [7:0] d);
    int n = 0;
    while (!m_start && n < 20) begin step(); n++; end
    chk("launch_wait", m_start, 1);
    t_launch = cyc; l_mode = m_mode; l_addr = m_address; l_reg = m_register;
    repeat (g1) step();
    m_ack = 1; step(); m_ack = 0;
    repeat (g2) step();
    if (np == 2) begin
      m_data = d; m_ack = 1; step(); m_ack = 0;
    end
  endtask
  task automatic wait_rsp(input int budget);
    int n = 0;
    while (!rsp_valid && n < budget) begin step(); n++; end
    chk("rsp_wait", rsp_valid, 1);
    t_rsp = cyc;
  endtask
  task automatic release_rsp();
    rsp_ready = 1; step(); rsp_ready = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    repeat (3) step();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_m_rst_n", m_rst_n, 0);
    reset = 1;
    chk("ready_pre_edge", cmd_ready, 0);
    step();
    chk("ready_post_edge", cmd_ready, 1);
    // write 0x48 / 0xA5
    issue(0, 7'h48, 8'hA5);
    run_master(2, 3, 2, 8'hEE);
    chk("wr_mode", l_mode, 0);
    chk("wr_addr", l_addr, 7'h48);
    chk("wr_reg", l_reg, 8'hA5);
    wait_rsp(100);
    chk("wr_data", rsp_data, 8'h00);
    chk("wr_err", rsp_err, 0);
    release_rsp();
    // fast read 0x50: accept edge + 2 mrst + launch + acks at wait edges 1 and 3 -> 6 edges
    issue(1, 7'h50, 8'h00);
    run_master(1, 1, 2, 8'h3C);
    wait_rsp(100);
    chk("rd_mode", l_mode, 1);
    chk("rd_data", rsp_data, 8'h3C);
    chk("rd_err", rsp_err, 0);
    chk("rd_latency", t_rsp - t_acc, 6);
    release_rsp();
    // address NACK: response appears TOUT edges after the launch cycle ends
    issue(1, 7'h21, 8'h00);
    run_master(3, 0, 1, 8'h77);
    wait_rsp(200);
    chk("nack_latency", t_rsp - t_launch, 65);
    chk("nack_err", rsp_err, 1);
    chk("nack_data", rsp_data, 8'h00);
    release_rsp();
    chk("nack_idle", busy, 0);
    // held response while a new command is offered
    issue(1, 7'h33, 8'h5A);
    run_master(1, 2, 2, 8'hC7);
    wait_rsp(100);
    cmd_valid = 1; cmd_addr = 7'h11; cmd_rw = 0;
    repeat (10) step();
    cmd_valid = 0;
    chk("hold_valid", rsp_valid, 1);
    chk("hold_data", rsp_data, 8'hC7);
    chk("hold_ready", cmd_ready, 0);
    release_rsp();
    chk("hold_drop", rsp_valid, 0);
    step();
    chk("hold_ignored", busy, 0);
    // reset in WAIT2, then a normal write
    issue(1, 7'h50, 8'h00);
    run_master(2, 0, 1, 8'h00);
    step(); step();
    chk("pre_rst_busy", busy, 1);
    reset = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_m_rst_n2", m_rst_n, 0);
    chk("rst_m_addr", m_address, 7'h00);
    repeat (3) step();
    reset = 1;
    step();
    chk("rst_ready_back", cmd_ready, 1);
    issue(0, 7'h48, 8'hC3);
    run_master(1, 1, 2, 8'hFF);
    wait_rsp(100);
    chk("post_rst_data", rsp_data, 8'h00);
    chk("post_rst_err", rsp_err, 0);
    release_rsp();
    // second ack exactly on the timeout edge wins
    issue(1, 7'h2A, 8'h00);
    run_master(10, TOUT - 11, 2, 8'h96);
    wait_rsp(100);
    chk("edge_to_err", rsp_err, 0);
    chk("edge_to_data", rsp_data, 8'h96);
    chk("edge_to_latency", t_rsp - t_launch, 65);
    release_rsp();
    // one edge later it is a timeout
    issue(1, 7'h2A, 8'h00);
    run_master(10, TOUT - 10, 2, 8'h96);
    wait_rsp(100);
    chk("late_err", rsp_err, 1);
    chk("late_data", rsp_data, 8'h00);
    release_rsp();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/i2c_sequencer.md
I2C_SEQUENCER -- requirements
Module: i2c_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: max clk cycles from master start to second m_ack rising edge.
REQ-002 SHALL have parameter MRST_CYCLES, default 2: clk cycles m_rst_n is held low before each transaction.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on posedge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1: command offered.
REQ-006 SHALL have port cmd_ready, output, 1: sequencer accepts a command.
REQ-007 SHALL have port cmd_rw, input, 1: 1 = read, 0 = write.
REQ-008 SHALL have port cmd_addr, input, 7: slave address.
REQ-009 SHALL have port cmd_reg, input, 8: write byte (write) or don't-care (read).
REQ-010 SHALL have port rsp_valid, output, 1: response held.
REQ-011 SHALL have port rsp_ready, input, 1: consumer takes the response.
REQ-012 SHALL have port rsp_data, output, 8: read byte (0 for writes).
REQ-013 SHALL have port rsp_err, output, 1: transaction timed out.
REQ-014 SHALL have port busy, output, 1: state is not IDLE.
REQ-015 SHALL have port m_rst_n, output, 1: active-low reset to the downstream I2C master.
REQ-016 SHALL have ports m_en, m_start, m_stop, m_repeat_start, m_mode, output, 1 each: master controls.
REQ-017 SHALL have ports m_address (output, 7) and m_register (output, 8): master operands.
REQ-018 SHALL have ports m_ack (input, 1) and m_data (input, 8): master ack flag and read byte.

Function
REQ-019 SHALL implement states IDLE, MRST, LAUNCH, WAIT1, WAIT2, RESP.
REQ-020 IDLE: cmd_ready=1; on cmd_valid, latch rw/addr/reg, clear the counter, and go to MRST.
REQ-021 MRST: m_rst_n=0 for MRST_CYCLES cycles, then go to LAUNCH with m_rst_n=1.
REQ-022 LAUNCH: assert m_en=1 and m_start=1 for exactly one cycle, clear the timeout counter, and go to WAIT1.
REQ-023 m_address, m_register, and m_mode=rw SHALL be driven from latched values from MRST through WAIT2; m_stop=1 and m_repeat_start=0 throughout.
REQ-024 m_ack rising edge SHALL be detected against a registered copy; WAIT1 advances to WAIT2 on the first edge.
REQ-025 WAIT2 SHALL, on the next m_ack rising edge, capture m_data into rsp_data if rw=1 (else 0), set rsp_err=0, and go to RESP.
REQ-026 In WAIT1/WAIT2 the counter SHALL increment each cycle; at TIMEOUT_CYCLES-1 without the needed edge: rsp_data=0, rsp_err=1, go to RESP.
REQ-027 An ack edge in the same cycle as timeout expiry SHALL win (success).
REQ-028 RESP: rsp_valid=1 with data/err stable; on rsp_ready go to IDLE and drop rsp_valid the next cycle. Zero-wait rsp_ready gives a one-cycle pulse.
REQ-029 cmd_ready SHALL be 0 outside IDLE; commands are not queued.
REQ-030 m_rst_n SHALL be 0 in IDLE, parking the master, and 1 only in LAUNCH/WAIT1/WAIT2.
REQ-031 Minimum cmd-accept to rsp_valid latency SHALL be MRST_CYCLES+3 cycles plus master time.

Reset
REQ-032 SHALL, while reset=0, force: state=IDLE, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, m_rst_n=0, all m_* controls and operands 0, counter 0, ack history 0.
REQ-033 Reset mid-transaction SHALL abort without a response; the master is held reset via m_rst_n=0.
REQ-034 cmd_ready SHALL rise on the first clk edge after reset deasserts.

Structure
REQ-035 SHALL place the state encoding, default TIMEOUT_CYCLES/MRST_CYCLES, and RW_READ/RW_WRITE constants in package i2c_seq_pkg.
REQ-036 SHALL be a single module with no sub-modules; it instantiates no master, and the top level wires m_* ports to the I2C master (m_rst_n to its reset).

Verification
REQ-037 Write 0x48/0xA5 against a behavioural master pulsing ack twice -> m_mode=0, m_register=0xA5, rsp_valid with rsp_data=0x00, rsp_err=0.
REQ-038 Read 0x50 with model m_data=0x3C -> rsp_data=0x3C, rsp_err=0, m_mode=1.
REQ-039 Address NACK (one ack pulse only) -> rsp_err=1 and rsp_data=0 exactly TIMEOUT_CYCLES cycles after LAUNCH, then IDLE.
REQ-040 Hold rsp_ready=0 for 10 cycles -> rsp_valid/rsp_data stable, cmd_ready=0, and a new cmd_valid is ignored.
REQ-041 Assert reset during WAIT2 -> all outputs at reset values, no rsp_valid; the next write completes normally.
REQ-042 Second ack edge on the timeout cycle -> rsp_err=0 and the data is captured.
